// File: rtl/conv_bitplane_acc_pkg.sv
// ============================================================
// conv_pkg : shared types and helpers for the bit-plane accumulator
// Rev 1.0
// ============================================================
`default_nettype none

package conv_pkg;

  localparam int PLANES_DEF = 8;
  localparam int PLANE_W    = $clog2(PLANES_DEF);

  // 2-bit mod-4 partial sum produced by the LUT stage
  typedef logic [1:0] beat_t;

  function automatic logic [31:0] plane_weight(input beat_t v, input int unsigned idx);
    return {30'd0, v} << idx;
  endfunction

endpackage

`default_nettype wire

// File: rtl/conv_bitplane_acc_if.sv
// ============================================================
// conv_bitplane_acc_if : beat input / window result handshake bundle
// Rev 1.0
// ============================================================
`default_nettype none

interface conv_bitplane_acc_if #(
  parameter int ACC_W   = 12,
  parameter int PLANE_W = 3
);
  logic               sync_clr;
  logic               in_valid;
  logic               in_ready;
  logic               din_bit1;
  logic               din_bit2;
  logic               out_valid;
  logic               out_ready;
  logic [ACC_W-1:0]   out_data;
  logic [PLANE_W-1:0] plane_idx;

  modport master (
    output sync_clr, in_valid, din_bit1, din_bit2, out_ready,
    input  in_ready, out_valid, out_data, plane_idx
  );

  modport slave (
    input  sync_clr, in_valid, din_bit1, din_bit2, out_ready,
    output in_ready, out_valid, out_data, plane_idx
  );
endinterface

`default_nettype wire

// File: rtl/conv_bitplane_acc_out_reg.sv
// ============================================================
// conv_out_reg : single-entry valid/ready result holding register
// Rev 1.0
// ============================================================
`default_nettype none

module conv_out_reg #(
  parameter int W = 12
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] load_data,
  input  logic         out_ready,
  output logic         out_valid,
  output logic [W-1:0] out_data
);

  logic         valid_q, valid_d;
  logic [W-1:0] data_q,  data_d;

  // A load in the same cycle as a drain keeps valid high with the new data
  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    if (load) begin
      valid_d = 1'b1;
      data_d  = load_data;
    end else if (valid_q && out_ready) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= 1'b0;
      data_q  <= '0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
    end
  end

  assign out_valid = valid_q;
  assign out_data  = data_q;

endmodule

`default_nettype wire

// File: rtl/conv_bitplane_acc.sv
// ============================================================
// conv_bitplane_acc : accumulates PLANES weighted 2-bit partial sums per window
// Rev 1.0
// ============================================================
`default_nettype none

module conv_bitplane_acc
  import conv_pkg::*;
#(
  parameter int PLANES = 8,
  parameter int ACC_W  = 12
) (
  input logic              clk,
  input logic              rst,
  conv_bitplane_acc_if.slave bus
);

  localparam int               IDX_W    = (PLANES > 1) ? $clog2(PLANES) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(PLANES - 1);

  generate
    if (PLANES < 2) begin : g_planes_check
      $error("conv_bitplane_acc: PLANES must be at least 2");
    end
    if (ACC_W < PLANES + 2) begin : g_width_check
      $error("conv_bitplane_acc: ACC_W must be at least PLANES+2");
    end
  endgenerate

  logic [IDX_W-1:0] plane_idx_q, plane_idx_d;
  logic [ACC_W-1:0] acc_q, acc_d;
  logic [ACC_W-1:0] contrib;
  logic [ACC_W-1:0] load_data;
  logic             load;
  logic             out_valid;
  logic             final_beat;
  logic             accept;
  beat_t            beat;

  assign beat       = {bus.din_bit2, bus.din_bit1};
  assign contrib    = ACC_W'(plane_weight(beat, 32'(plane_idx_q)));
  assign final_beat = (plane_idx_q == LAST_IDX);
  // Only the final beat can be stalled, and only by an undrained result
  assign bus.in_ready = !bus.sync_clr && !(final_beat && out_valid && !bus.out_ready);
  assign accept       = bus.in_valid && bus.in_ready;
  assign load_data    = acc_q + contrib;

  always_comb begin
    acc_d       = acc_q;
    plane_idx_d = plane_idx_q;
    load        = 1'b0;
    if (bus.sync_clr) begin
      acc_d       = '0;
      plane_idx_d = '0;
    end else if (accept) begin
      if (final_beat) begin
        acc_d       = '0;
        plane_idx_d = '0;
        load        = 1'b1;
      end else begin
        acc_d       = load_data;
        plane_idx_d = plane_idx_q + IDX_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      acc_q       <= '0;
      plane_idx_q <= '0;
    end else begin
      acc_q       <= acc_d;
      plane_idx_q <= plane_idx_d;
    end
  end

  conv_out_reg #(
    .W (ACC_W)
  ) u_out_reg (
    .clk       (clk),
    .rst       (rst),
    .load      (load),
    .load_data (load_data),
    .out_ready (bus.out_ready),
    .out_valid (out_valid),
    .out_data  (bus.out_data)
  );

  assign bus.out_valid = out_valid;
  assign bus.plane_idx = plane_idx_q;

endmodule

`default_nettype wire
